demux_1to2_stream: RTL and testbench
====================================

Name: demux_1to2_stream

Overview:
- Streaming 1-to-2 demultiplexer with buffering: the routing counterpart of the 2:1 selector.
- Accepts WIDTH-bit beats on one valid/ready input and steers each beat to output 0 or output 1 according to sel sampled with the beat.
- Each output has its own FIFO, so a stalled output does not lose data.
- Sits between a single producer and two downstream consumers. Also provides per-output delivered-beat counters for debug.

Parameters:
- WIDTH, 2, data width of in, out0, out1.
- DEPTH, 2, entries per output FIFO; power of two, >= 2.
- CNT_W, 8, width of each delivered-beat counter.

Ports:
- clk  input  1  rising-edge clock for all state.
- reset_n  input  1  asynchronous, active-low reset.
- in  input  WIDTH  input beat data.
- sel  input  1  destination of the current beat: 0 -> out0, 1 -> out1.
- in_valid  input  1  producer has a beat on in/sel.
- in_ready  output  1  block accepts the beat this cycle.
- out0  output  WIDTH  head of FIFO 0.
- out0_valid  output  1  FIFO 0 non-empty.
- out0_ready  input  1  consumer 0 takes the head this cycle.
- out1  output  WIDTH  head of FIFO 1.
- out1_valid  output  1  FIFO 1 non-empty.
- out1_ready  input  1  consumer 1 takes the head this cycle.
- cnt0  output  CNT_W  beats delivered on output 0.
- cnt1  output  CNT_W  beats delivered on output 1.

Behaviour:
- Reset (reset_n low, asynchronous, any cycle including mid-transfer):
  - Both FIFOs are emptied; read/write pointers and occupancy go to 0.
  - Storage is cleared to 0.
  - out0_valid = out1_valid = 0, out0 = out1 = 0, cnt0 = cnt1 = 0.
  - Any beat in flight is discarded.
  - in_ready is 0 while reset_n is low. After release it follows the ready rule below.
- Ready rule (combinational):
  - in_ready = ~full0 when sel = 0, ~full1 when sel = 1.
  - in_ready depends only on sel and the registered full flags. It must not depend on in_valid or on out*_ready.
  - No pass-through: a full FIFO stays not-ready in a cycle where it is also being popped.
- Accept: beat accepted on a rising edge with in_valid & in_ready. in is written to FIFO[sel]; that write pointer advances modulo DEPTH.
- Deliver:
  - Pop FIFO k on a rising edge with outk_valid & outk_ready. The read pointer advances modulo DEPTH and cntk increments.
  - cntk wraps from 2^CNT_W-1 to 0.
- Latency and ordering:
  - A beat accepted at edge N appears at outk with outk_valid = 1 from edge N (registered) and can be popped at edge N+1 at the earliest. Minimum latency is 1 cycle.
  - Order is preserved within each output. No ordering is defined across outputs.
- Outputs: outk = FIFO k head entry, combinational read of registered storage. outk_valid = (occupancy_k != 0), registered.
- Full/empty: each FIFO keeps an occupancy counter 0..DEPTH, or pointers plus a wrap bit.
  - fullk = (occupancy_k == DEPTH).
  - Simultaneous push and pop on the same FIFO (possible only when not full and not empty) leaves occupancy unchanged; both pointers advance.
- Independence:
  - Push to FIFO 0 and pop from FIFO 1 in the same cycle are independent.
  - Both FIFOs may pop in the same cycle.
- Protocol:
  - Producer keeps in/sel/in_valid stable while in_valid & ~in_ready.
  - outk/outk_valid are stable while outk_valid & ~outk_ready.
  - outk_ready while outk_valid = 0 has no effect: no pointer or counter change.
- X-safety: in_valid = 0 with sel or in = X must not corrupt state.

Test Plan:
- Reset then idle, in_valid = 0 for 5 cycles -> out0_valid = out1_valid = 0, out0 = out1 = 0, cnt0 = cnt1 = 0, in_ready = 1 for either sel.
- Route with both readies = 1:
  - Stimulus: in = 2'b01 sel = 0, then in = 2'b10 sel = 1, then in = 2'b11 sel = 0, one per cycle.
  - Expected: out0 shows 01 then 11; out1 shows 10; each valid is high 1 cycle after its accept; final cnt0 = 2, cnt1 = 1.
- Backpressure:
  - Stimulus: out0_ready = 0, push 00, 01, then attempt 10, all sel = 0.
  - Expected: after 2 accepts in_ready = 0 for sel = 0, third beat held; switching sel = 1 shows in_ready = 1.
  - Then raise out0_ready: next pop shows 00; the following edge accepts 10; the drain order is 00, 01, 10.
- Full and pop same cycle: with FIFO 0 full, in_valid = 1 sel = 0 and out0_ready = 1 -> no accept that edge (no pass-through); accept on the next edge; occupancy returns to 2.
- Counter wrap, CNT_W = 8: deliver 256 beats on out1 -> cnt1 reads 255 then 0; cnt0 stays 0.
- Reset mid-operation: FIFO 0 holds 2 beats and FIFO 1 holds 1, then assert reset_n low between edges -> outputs clear immediately without waiting for a clock. After release, no stale beat appears and the counters restart at 0.

Source files
------------

// File: rtl/demux_1to2_stream.sv
// demux_1to2_stream: streaming 1-to-2 demultiplexer with one FIFO per output.
//
// Each input beat goes to out0 or out1, chosen by the sel value that arrives
// with the beat. Each output has its own FIFO, so a stalled consumer does not
// block or drop beats meant for the other output.
//
// Ports
//   clk, reset_n          : rising-edge clock; asynchronous active-low reset
//   in, sel, in_valid     : producer beat and its destination (0 -> out0, 1 -> out1)
//   in_ready              : beat accepted this cycle (~full of the selected FIFO)
//   outK, outK_valid      : head of FIFO K and its non-empty flag
//   outK_ready            : consumer K pops the head
//   cnt0, cnt1            : wrapping count of beats delivered on each output

// Per-output FIFO with a delivered-beat counter.
//   i_push    : write i_data (ignored while full)
//   i_pop_rdy : consumer ready; pops only when the FIFO is non-empty
//   o_data    : head entry (combinational read of registered storage)
//   o_valid   : registered non-empty flag
//   o_full    : registered full flag
//   o_cnt     : delivered beats, wraps at 2^CNT_W
module demux_1to2_stream_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop_rdy,
  output logic             o_full,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [CNT_W-1:0] o_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] r_mem;
  logic [AW-1:0]               r_wptr, r_rptr;
  logic [AW:0]                 r_occ;
  logic                        r_full, r_valid;
  logic [CNT_W-1:0]            r_cnt;
  logic [AW:0]                 w_occ_nxt;
  logic                        w_push, w_pop;

  // Push is gated by full locally as well, so the FIFO never overwrites even
  // if the caller misbehaves. Pop needs a non-empty FIFO.
  assign w_push = i_push & ~r_full;
  assign w_pop  = i_pop_rdy & r_valid;

  always_comb begin
    w_occ_nxt = r_occ;
    case ({w_push, w_pop})
      2'b10:   w_occ_nxt = r_occ + 1'b1;
      2'b01:   w_occ_nxt = r_occ - 1'b1;
      default: w_occ_nxt = r_occ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_occ   <= '0;
      r_full  <= 1'b0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= r_wptr + 1'b1;  // DEPTH is a power of two: natural wrap
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
        r_cnt  <= r_cnt + 1'b1;
      end
      r_occ   <= w_occ_nxt;
      r_full  <= (w_occ_nxt == FULL_OCC);
      r_valid <= (w_occ_nxt != '0);
    end
  end

  assign o_full  = r_full;
  assign o_valid = r_valid;
  assign o_data  = r_mem[r_rptr];
  assign o_cnt   = r_cnt;
endmodule

module demux_1to2_stream #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in,
  input  logic             sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);
  logic [1:0]            w_full, w_valid, w_rdy, w_push;
  logic [1:0][WIDTH-1:0] w_data;
  logic [1:0][CNT_W-1:0] w_cnt;
  logic                  w_acc;

  // Ready looks only at sel and the registered full flags, so a full FIFO
  // stays not-ready even in a cycle where it is being popped. The reset_n
  // term holds ready low while reset is asserted.
  assign in_ready = reset_n & ~w_full[sel];

  // in_valid is ANDed in first so an idle cycle with X on sel/in cannot push.
  assign w_acc     = in_valid & in_ready;
  assign w_push[0] = w_acc & ~sel;
  assign w_push[1] = w_acc &  sel;
  assign w_rdy     = {out1_ready, out0_ready};

  for (genvar k = 0; k < 2; k++) begin : g_out
    demux_1to2_stream_fifo #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH),
      .CNT_W(CNT_W)
    ) u_fifo (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_push   (w_push[k]),
      .i_data   (in),
      .i_pop_rdy(w_rdy[k]),
      .o_full   (w_full[k]),
      .o_valid  (w_valid[k]),
      .o_data   (w_data[k]),
      .o_cnt    (w_cnt[k])
    );
  end

  assign out0       = w_data[0];
  assign out1       = w_data[1];
  assign out0_valid = w_valid[0];
  assign out1_valid = w_valid[1];
  assign cnt0       = w_cnt[0];
  assign cnt1       = w_cnt[1];
endmodule

// File: tb/tb_demux_1to2_stream.sv
// Directed bench for demux_1to2_stream (WIDTH=2, DEPTH=2, CNT_W=8).
module tb_demux_1to2_stream;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] in;
  logic       sel, in_valid, in_ready;
  logic [1:0] out0, out1;
  logic       out0_valid, out0_ready, out1_valid, out1_ready;
  logic [7:0] cnt0, cnt1;

  int tests = 0;
  int fails = 0;

  demux_1to2_stream #(.WIDTH(2), .DEPTH(2), .CNT_W(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in        (in),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out0      (out0),
    .out0_valid(out0_valid),
    .out0_ready(out0_ready),
    .out1      (out1),
    .out1_valid(out1_valid),
    .out1_ready(out1_ready),
    .cnt0      (cnt0),
    .cnt1      (cnt1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0; in = '0; sel = 1'b0; in_valid = 1'b0;
    out0_ready = 1'b0; out1_ready = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_v0", out0_valid, 0);
    #12 reset_n = 1'b1;

    // Idle after reset
    repeat (5) tick();
    chk("idle_v0", out0_valid, 0);
    chk("idle_v1", out1_valid, 0);
    chk("idle_out0", out0, 0);
    chk("idle_out1", out1, 0);
    chk("idle_cnt0", cnt0, 0);
    chk("idle_cnt1", cnt1, 0);
    chk("idle_rdy_s0", in_ready, 1);
    sel = 1'b1; #1;
    chk("idle_rdy_s1", in_ready, 1);
    sel = 1'b0;

    // Routing with both consumers ready
    out0_ready = 1'b1; out1_ready = 1'b1;
    in = 2'b01; sel = 1'b0; in_valid = 1'b1;
    tick();
    chk("rt1_v0", out0_valid, 1);
    chk("rt1_out0", out0, 2'b01);
    chk("rt1_v1", out1_valid, 0);
    in = 2'b10; sel = 1'b1;
    tick();
    chk("rt2_v1", out1_valid, 1);
    chk("rt2_out1", out1, 2'b10);
    chk("rt2_v0", out0_valid, 0);
    chk("rt2_cnt0", cnt0, 1);
    in = 2'b11; sel = 1'b0;
    tick();
    chk("rt3_out0", out0, 2'b11);
    chk("rt3_v0", out0_valid, 1);
    chk("rt3_v1", out1_valid, 0);
    chk("rt3_cnt1", cnt1, 1);
    in_valid = 1'b0;
    tick();
    chk("rt4_cnt0", cnt0, 2);
    chk("rt4_cnt1", cnt1, 1);
    chk("rt4_v0", out0_valid, 0);

    // X on sel/in while idle must not change state
    sel = 1'bx; in = 2'bxx;
    tick();
    chk("x_v0", out0_valid, 0);
    chk("x_v1", out1_valid, 0);
    chk("x_cnt0", cnt0, 2);

    // Backpressure on output 0
    out0_ready = 1'b0; in = 2'b00; sel = 1'b0; in_valid = 1'b1;
    tick();
    in = 2'b01;
    tick();
    chk("bp_head", out0, 2'b00);
    in = 2'b10; #1;
    chk("bp_full_rdy", in_ready, 0);
    tick();
    chk("bp_held_head", out0, 2'b00);
    chk("bp_held_cnt0", cnt0, 2);
    sel = 1'b1; #1;
    chk("bp_rdy_s1", in_ready, 1);
    sel = 1'b0;
    // Full and popping in the same cycle: still not ready
    out0_ready = 1'b1; #1;
    chk("nopass_rdy", in_ready, 0);
    tick();
    chk("nopass_head", out0, 2'b01);
    chk("nopass_cnt0", cnt0, 3);
    chk("nopass_rdy_after", in_ready, 1);
    out0_ready = 1'b0;
    tick();
    chk("refill_rdy", in_ready, 0);
    chk("refill_head", out0, 2'b01);
    in_valid = 1'b0; out0_ready = 1'b1;
    tick();
    chk("drain_head", out0, 2'b10);
    chk("drain_cnt0", cnt0, 4);
    tick();
    chk("drain_v0", out0_valid, 0);
    chk("drain_cnt0_end", cnt0, 5);

    // Counter wrap on output 1 (cnt1 starts at 1)
    sel = 1'b1; out1_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 254; i++) begin
      in = 2'(i);
      tick();
    end
    chk("wrap_stream_out1", out1, 2'b01);
    in_valid = 1'b0;
    tick();
    chk("wrap_cnt1_255", cnt1, 255);
    chk("wrap_cnt0", cnt0, 5);
    chk("wrap_v1", out1_valid, 0);
    in = 2'b11; in_valid = 1'b1;
    tick();
    chk("wrap_last_out1", out1, 2'b11);
    chk("wrap_cnt1_hold", cnt1, 255);
    in_valid = 1'b0;
    tick();
    chk("wrap_cnt1_0", cnt1, 0);
    chk("wrap_cnt0_end", cnt0, 5);

    // Reset in the middle of operation
    out0_ready = 1'b0; out1_ready = 1'b0;
    in_valid = 1'b1; sel = 1'b0; in = 2'b01;
    tick();
    in = 2'b10;
    tick();
    sel = 1'b1; in = 2'b11;
    tick();
    in_valid = 1'b0;
    chk("mid_v0", out0_valid, 1);
    chk("mid_v1", out1_valid, 1);
    chk("mid_out0", out0, 2'b01);
    chk("mid_out1", out1, 2'b11);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_v0", out0_valid, 0);
    chk("arst_v1", out1_valid, 0);
    chk("arst_out0", out0, 0);
    chk("arst_out1", out1, 0);
    chk("arst_cnt0", cnt0, 0);
    chk("arst_rdy", in_ready, 0);
    #3 reset_n = 1'b1;
    out0_ready = 1'b1; out1_ready = 1'b1;
    repeat (3) tick();
    chk("post_v0", out0_valid, 0);
    chk("post_v1", out1_valid, 0);
    chk("post_cnt0", cnt0, 0);
    chk("post_cnt1", cnt1, 0);
    in = 2'b10; sel = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("post_out1", out1, 2'b10);
    chk("post_v1_new", out1_valid, 1);
    tick();
    chk("post_cnt1_new", cnt1, 1);
    chk("post_v1_end", out1_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
